rv_run_ctrl: RTL and testbench

Run controller for the pipelined RISC-V core and its instruction/data BRAMs. It lets a host preload IMEM/DMEM over a simple write port while the core is held in reset. On a start command it releases the core, watches the core's done flag, and enforces a cycle timeout. It owns the BRAM-side ports and muxes them between the host, when the core is halted, and the core, when it is running.

---
 rtl/rv_run_ctrl.sv | 146 ++++++++++++++
 tb/tb_rv_run_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_run_ctrl.sv
// Run controller: host preloads IMEM/DMEM while the core is held in reset, then runs it
// under a done/timeout watch. BRAM ports are muxed by registered state: host when halted, core when running.
module rv_run_ctrl #(
  parameter int RST_HOLD       = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             host_wr_valid,
  output logic             host_wr_ready,
  input  logic             host_wr_sel,
  input  logic [31:0]      host_wr_addr,
  input  logic [31:0]      host_wr_data,
  output logic             core_rst_n,
  input  logic [31:0]      core_imem_addr,
  input  logic             core_imem_en,
  input  logic [31:0]      core_dmem_addr,
  input  logic             core_dmem_en,
  input  logic [3:0]       core_dmem_we,
  input  logic [31:0]      core_dmem_din,
  input  logic             core_done,
  output logic [31:0]      imem_addr,
  output logic             imem_en,
  output logic [3:0]       imem_we,
  output logic [31:0]      imem_din,
  output logic [31:0]      dmem_addr,
  output logic             dmem_en,
  output logic [3:0]       dmem_we,
  output logic [31:0]      dmem_din,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int HW = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);
  localparam logic [HW-1:0]    HOLD_INIT = HW'(RST_HOLD);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_RESET_CORE, S_RUN, S_DONE, S_TIMEOUT
  } state_e;

  state_e           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             core_rst_n_q, busy_q, done_q, timeout_q;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_TIMEOUT: begin
          if (start) begin
            state_d = S_RESET_CORE;
            cnt_d   = '0;
            hold_d  = HOLD_INIT;
          end
        end
        S_RESET_CORE: begin
          if (hold_q != '0) hold_d = hold_q - HW'(1);
          if (hold_q <= HW'(1)) state_d = S_RUN;
        end
        S_RUN: begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          // done has priority; the sampling cycle is already counted above
          if (core_done) begin
            state_d = S_DONE;
          end else if (TIMEOUT_CYCLES != 0 && cnt_q == TO_LAST) begin
            state_d = S_TIMEOUT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      cnt_q        <= '0;
      core_rst_n_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      core_rst_n_q <= (state_d == S_RUN);
      busy_q       <= (state_d == S_RESET_CORE) || (state_d == S_RUN);
      done_q       <= (state_d == S_DONE);
      timeout_q    <= (state_d == S_TIMEOUT);
    end
  end

  assign core_rst_n  = core_rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;

  logic core_own;
  logic host_wr;
  assign core_own      = (state_q == S_RESET_CORE) || (state_q == S_RUN);
  assign host_wr_ready = ~core_own;
  assign host_wr       = host_wr_valid & host_wr_ready;

  always_comb begin
    imem_addr = host_wr_addr;
    imem_en   = 1'b0;
    imem_we   = 4'b0000;
    imem_din  = host_wr_data;
    dmem_addr = host_wr_addr;
    dmem_en   = 1'b0;
    dmem_we   = 4'b0000;
    dmem_din  = host_wr_data;
    if (core_own) begin
      imem_addr = core_imem_addr;
      imem_en   = core_imem_en;
      imem_din  = 32'h0;
      dmem_addr = core_dmem_addr;
      dmem_en   = core_dmem_en;
      dmem_we   = core_dmem_we;
      dmem_din  = core_dmem_din;
    end else if (host_wr) begin
      if (host_wr_sel) begin
        dmem_en = 1'b1;
        dmem_we = 4'b1111;
      end else begin
        imem_en = 1'b1;
        imem_we = 4'b1111;
      end
    end
  end

endmodule

// File: tb/tb_rv_run_ctrl.sv
// Scoreboarded bench for rv_run_ctrl: two instances share stimulus, one with a 50-cycle timeout.
module tb_rv_run_ctrl;

  logic        clk, rst_n, start, abort;
  logic        host_wr_valid, host_wr_sel;
  logic [31:0] host_wr_addr, host_wr_data;
  logic [31:0] core_imem_addr, core_dmem_addr, core_dmem_din;
  logic        core_imem_en, core_dmem_en, core_done;
  logic [3:0]  core_dmem_we;

  logic        a_host_wr_ready, a_core_rst_n, a_imem_en, a_dmem_en, a_busy, a_done, a_timeout;
  logic [31:0] a_imem_addr, a_imem_din, a_dmem_addr, a_dmem_din, a_cycle_count;
  logic [3:0]  a_imem_we, a_dmem_we;
  logic        b_host_wr_ready, b_core_rst_n, b_imem_en, b_dmem_en, b_busy, b_done, b_timeout;
  logic [31:0] b_imem_addr, b_imem_din, b_dmem_addr, b_dmem_din, b_cycle_count;
  logic [3:0]  b_imem_we, b_dmem_we;

  rv_run_ctrl #(.RST_HOLD(4), .TIMEOUT_CYCLES(1000000), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .host_wr_valid(host_wr_valid), .host_wr_ready(a_host_wr_ready), .host_wr_sel(host_wr_sel),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .core_rst_n(a_core_rst_n),
    .core_imem_addr(core_imem_addr), .core_imem_en(core_imem_en),
    .core_dmem_addr(core_dmem_addr), .core_dmem_en(core_dmem_en), .core_dmem_we(core_dmem_we),
    .core_dmem_din(core_dmem_din), .core_done(core_done),
    .imem_addr(a_imem_addr), .imem_en(a_imem_en), .imem_we(a_imem_we), .imem_din(a_imem_din),
    .dmem_addr(a_dmem_addr), .dmem_en(a_dmem_en), .dmem_we(a_dmem_we), .dmem_din(a_dmem_din),
    .busy(a_busy), .done(a_done), .timeout(a_timeout), .cycle_count(a_cycle_count)
  );

  rv_run_ctrl #(.RST_HOLD(4), .TIMEOUT_CYCLES(50), .CNT_W(32)) dut_to (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .host_wr_valid(host_wr_valid), .host_wr_ready(b_host_wr_ready), .host_wr_sel(host_wr_sel),
    .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data), .core_rst_n(b_core_rst_n),
    .core_imem_addr(core_imem_addr), .core_imem_en(core_imem_en),
    .core_dmem_addr(core_dmem_addr), .core_dmem_en(core_dmem_en), .core_dmem_we(core_dmem_we),
    .core_dmem_din(core_dmem_din), .core_done(core_done),
    .imem_addr(b_imem_addr), .imem_en(b_imem_en), .imem_we(b_imem_we), .imem_din(b_imem_din),
    .dmem_addr(b_dmem_addr), .dmem_en(b_dmem_en), .dmem_we(b_dmem_we), .dmem_din(b_dmem_din),
    .busy(b_busy), .done(b_done), .timeout(b_timeout), .cycle_count(b_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct { logic sel; logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic is_to; logic [31:0] cnt; } res_t;
  wr_t  wq[$];
  res_t rqa[$];
  res_t rqb[$];
  wr_t  mw;
  res_t mr;
  logic pa_end = 1'b0, pb_end = 1'b0;

  // Monitor: pops expected host writes and run outcomes as the DUTs produce them
  always @(negedge clk) begin
    if (rst_n) begin
      if (!a_busy && (a_imem_en || a_dmem_en)) begin
        if (wq.size() == 0) begin
          chk("unexpected_wr", 1, 0);
        end else begin
          mw = wq.pop_front();
          chk("wr_sel", a_dmem_en, mw.sel);
          chk("wr_other_en", mw.sel ? a_imem_en : a_dmem_en, 0);
          chk("wr_imem_we", a_imem_we, mw.sel ? 4'h0 : 4'hf);
          chk("wr_dmem_we", a_dmem_we, mw.sel ? 4'hf : 4'h0);
          chk("wr_addr", mw.sel ? a_dmem_addr : a_imem_addr, mw.addr);
          chk("wr_data", mw.sel ? a_dmem_din : a_imem_din, mw.data);
        end
      end
      if ((a_done || a_timeout) && !pa_end) begin
        if (rqa.size() == 0) chk("unexpected_end_a", 1, 0);
        else begin
          mr = rqa.pop_front();
          chk("end_kind_a", a_timeout, mr.is_to);
          chk("end_count_a", a_cycle_count, mr.cnt);
        end
      end
      if ((b_done || b_timeout) && !pb_end) begin
        if (rqb.size() == 0) chk("unexpected_end_b", 1, 0);
        else begin
          mr = rqb.pop_front();
          chk("end_kind_b", b_timeout, mr.is_to);
          chk("end_count_b", b_cycle_count, mr.cnt);
        end
      end
      pa_end = a_done || a_timeout;
      pb_end = b_done || b_timeout;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic sel, input logic [31:0] addr, input logic [31:0] data);
    tick;
    host_wr_valid = 1'b1;
    host_wr_sel   = sel;
    host_wr_addr  = addr;
    host_wr_data  = data;
    wq.push_back('{sel, addr, data});
    @(negedge clk);
    chk("wr_ready", a_host_wr_ready, 1);
    tick;
    host_wr_valid = 1'b0;
  endtask

  task automatic start_pulse;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  // Returns at the negedge of the first RUN cycle; n = RESET_CORE cycles seen
  task automatic wait_run(output int n);
    bit ok;
    n  = 0;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (a_core_rst_n) ok = 1;
      else if (a_busy) n++;
    end
    if (!ok) chk("wait_run_bound", 0, 1);
  endtask

  task automatic run_until(input int n);
    repeat (n - 1) tick;
    core_done = 1'b1;
    tick;
    core_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int hold_n;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    host_wr_valid = 1'b0; host_wr_sel = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    core_imem_addr = '0; core_imem_en = 1'b0; core_dmem_addr = '0;
    core_dmem_en = 1'b0; core_dmem_we = '0; core_dmem_din = '0; core_done = 1'b0;

    @(negedge clk);
    chk("rst_core_rst_n", a_core_rst_n, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_timeout", a_timeout, 0);
    chk("rst_count", a_cycle_count, 0);
    chk("rst_ready", a_host_wr_ready, 1);
    #2 rst_n = 1'b1;

    host_write(1'b0, 32'h0, 32'h0000_0013);
    host_write(1'b0, 32'h4, 32'h0000_0013);
    host_write(1'b0, 32'h8, 32'h0000_0013);
    host_write(1'b1, 32'h2000, 32'h0);
    @(negedge clk);
    chk("idle_no_imem_en", a_imem_en, 0);
    chk("idle_no_dmem_en", a_dmem_en, 0);

    // Run 1: done at RUN cycle 100; the 50-cycle instance times out meanwhile
    core_imem_addr = 32'h100; core_imem_en = 1'b1; core_dmem_addr = 32'h2004;
    core_dmem_en = 1'b1; core_dmem_we = 4'b0101; core_dmem_din = 32'hdead_beef;
    rqa.push_back('{1'b0, 32'd100});
    rqb.push_back('{1'b1, 32'd50});
    start_pulse;
    wait_run(hold_n);
    chk("rst_hold_cycles", hold_n, 4);
    chk("run_busy", a_busy, 1);
    chk("run_ready", a_host_wr_ready, 0);
    chk("mir_imem_addr", a_imem_addr, 32'h100);
    chk("mir_imem_en", a_imem_en, 1);
    chk("mir_imem_we", a_imem_we, 0);
    chk("mir_imem_din", a_imem_din, 0);
    chk("mir_dmem_addr", a_dmem_addr, 32'h2004);
    chk("mir_dmem_en", a_dmem_en, 1);
    chk("mir_dmem_we", a_dmem_we, 4'b0101);
    chk("mir_dmem_din", a_dmem_din, 32'hdead_beef);
    for (int k = 2; k <= 100; k++) begin
      tick;
      if (k == 2) begin
        core_imem_en = 1'b0; core_dmem_en = 1'b0; core_dmem_we = '0;
      end
      start = (k == 20);
      if (k == 100) core_done = 1'b1;
    end
    tick;
    core_done = 1'b0;
    @(negedge clk);
    chk("done_flag", a_done, 1);
    chk("done_count", a_cycle_count, 100);
    chk("done_core_rst_n", a_core_rst_n, 0);
    chk("done_busy", a_busy, 0);
    chk("done_ready", a_host_wr_ready, 1);
    chk("to_flag", b_timeout, 1);
    chk("to_done", b_done, 0);
    chk("to_count", b_cycle_count, 50);
    chk("to_core_rst_n", b_core_rst_n, 0);

    // Run 2: done and timeout together at cycle 50; host write stalls through RUN
    rqa.push_back('{1'b0, 32'd50});
    rqb.push_back('{1'b0, 32'd50});
    start_pulse;
    @(negedge clk);
    chk("start_clears_count", a_cycle_count, 0);
    wait_run(hold_n);
    host_wr_valid = 1'b1; host_wr_sel = 1'b1;
    host_wr_addr = 32'h2008; host_wr_data = 32'ha5a5_0001;
    wq.push_back('{1'b1, 32'h2008, 32'ha5a5_0001});
    chk("stall_ready", a_host_wr_ready, 0);
    chk("stall_no_dmem_en", a_dmem_en, 0);
    run_until(50);
    @(negedge clk);
    chk("tie_done", b_done, 1);
    chk("tie_timeout", b_timeout, 0);
    tick;
    host_wr_valid = 1'b0;

    // Run 3: abort together with start after 10 RUN cycles
    start_pulse;
    wait_run(hold_n);
    repeat (10) tick;
    abort = 1'b1; start = 1'b1;
    tick;
    abort = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    chk("abort_core_rst_n", a_core_rst_n, 0);
    chk("abort_count", a_cycle_count, 10);
    tick;
    @(negedge clk);
    chk("abort_stays_idle", a_busy, 0);

    // Run 4: async reset in the middle of RUN, then a normal run
    start_pulse;
    wait_run(hold_n);
    repeat (3) tick;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_core_rst_n", a_core_rst_n, 0);
    chk("arst_busy", a_busy, 0);
    chk("arst_count", a_cycle_count, 0);
    chk("arst_done", a_done, 0);
    chk("arst_timeout", a_timeout, 0);
    chk("arst_ready", a_host_wr_ready, 1);
    #3 rst_n = 1'b1;
    rqa.push_back('{1'b0, 32'd5});
    rqb.push_back('{1'b0, 32'd5});
    start_pulse;
    wait_run(hold_n);
    chk("post_arst_hold", hold_n, 4);
    run_until(5);
    @(negedge clk);
    chk("post_arst_done", a_done, 1);

    repeat (3) tick;
    chk("wq_drained", wq.size(), 0);
    chk("rqa_drained", rqa.size(), 0);
    chk("rqb_drained", rqb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
